// File: rtl/mem_arbiter_if.sv
// Memory-controller side of mem_arbiter: one outstanding request at a time.
// The arbiter drives the master modport and the sram/SDRAM controller the slave modport.
interface mem_arbiter_if #(
  parameter int AW = 25
);
  // Handshake: mem_req rises with address, write enable and data already stable.
  // It stays high until the controller returns a single-cycle mem_ack, and read data
  // on mem_dout is valid only in that mem_ack cycle. mem_req drops on the next edge.
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [15:0]   mem_dout;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_din,
    input  mem_dout,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_din,
    output mem_dout,
    output mem_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Four-way arbiter for the shared 16-bit memory port: video > CPU > FDD > ioctl,
// with FDD/ioctl aging so a busy CPU cannot starve disk image traffic.
module mem_arbiter #(
  parameter int AW        = 25,
  parameter int AGE_W     = 4,
  parameter int AGE_LIMIT = 15
) (
  input  logic          clk_sys,
  input  logic          reset,

  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [15:0]   vid_dout,
  output logic          vid_ack,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,

  input  logic          fdd_req,
  input  logic [AW-1:0] fdd_addr,
  output logic [7:0]    fdd_dout,
  output logic          fdd_ack,

  input  logic          io_req,
  input  logic [AW-1:0] io_addr,
  input  logic [7:0]    io_din,
  output logic          io_ack,

  mem_arbiter_if.master mem,

  output logic          busy,
  output logic [1:0]    grant,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] G_VID = 2'd0;
  localparam logic [1:0] G_CPU = 2'd1;
  localparam logic [1:0] G_FDD = 2'd2;
  localparam logic [1:0] G_IO  = 2'd3;

  localparam logic [AGE_W-1:0] AGE_THRESH = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX    = {AGE_W{1'b1}};

  state_t          state_q,    state_d;
  logic [1:0]      grant_q,    grant_d;
  logic            mem_req_q,  mem_req_d;
  logic            mem_we_q,   mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q,  mem_din_d;
  logic            busy_q,     busy_d;
  logic [15:0]     vid_dout_q, vid_dout_d;
  logic [7:0]      cpu_dout_q, cpu_dout_d;
  logic [7:0]      fdd_dout_q, fdd_dout_d;
  logic            vid_ack_q,  vid_ack_d;
  logic            cpu_ack_q,  cpu_ack_d;
  logic            fdd_ack_q,  fdd_ack_d;
  logic            io_ack_q,   io_ack_d;
  logic [AGE_W-1:0] fdd_age_q, fdd_age_d;
  logic [AGE_W-1:0] io_age_q,  io_age_d;

  logic            any_req;
  logic            fdd_aged;
  logic            io_aged;
  logic [1:0]      win;
  logic [7:0]      rd_byte;

  // Winner selection; aged FDD/ioctl requests jump ahead of the CPU but never video.
  always_comb begin
    any_req  = vid_req | cpu_req | fdd_req | io_req;
    fdd_aged = fdd_req && (fdd_age_q >= AGE_THRESH);
    io_aged  = io_req  && (io_age_q  >= AGE_THRESH);
    win      = G_VID;
    if (vid_req)       win = G_VID;
    else if (fdd_aged) win = G_FDD;
    else if (io_aged)  win = G_IO;
    else if (cpu_req)  win = G_CPU;
    else if (fdd_req)  win = G_FDD;
    else if (io_req)   win = G_IO;
  end

  // Byte lanes: even byte address on [7:0], odd on [15:8].
  assign rd_byte = mem_addr_q[0] ? mem.mem_dout[15:8] : mem.mem_dout[7:0];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    busy_d     = busy_q;
    vid_dout_d = vid_dout_q;
    cpu_dout_d = cpu_dout_q;
    fdd_dout_d = fdd_dout_q;
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    fdd_ack_d  = 1'b0;
    io_ack_d   = 1'b0;
    fdd_age_d  = fdd_age_q;
    io_age_d   = io_age_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d   = S_BUSY;
          grant_d   = win;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          case (win)
            G_VID: begin
              mem_addr_d = vid_addr;
              mem_we_d   = 1'b0;
              mem_din_d  = 8'h00;
            end
            G_CPU: begin
              mem_addr_d = cpu_addr;
              mem_we_d   = cpu_we;
              mem_din_d  = cpu_din;
            end
            G_FDD: begin
              mem_addr_d = fdd_addr;
              mem_we_d   = 1'b0;
              mem_din_d  = 8'h00;
            end
            default: begin
              mem_addr_d = io_addr;
              mem_we_d   = 1'b1;
              mem_din_d  = io_din;
            end
          endcase
        end

        // Ages only move while arbitration is live; they freeze in BUSY/DONE.
        if (!fdd_req || (any_req && win == G_FDD)) fdd_age_d = '0;
        else if (fdd_age_q != AGE_MAX)             fdd_age_d = fdd_age_q + 1'b1;

        if (!io_req || (any_req && win == G_IO)) io_age_d = '0;
        else if (io_age_q != AGE_MAX)            io_age_d = io_age_q + 1'b1;
      end

      S_BUSY: begin
        if (mem.mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          case (grant_q)
            G_VID: begin
              vid_dout_d = mem.mem_dout;
              vid_ack_d  = 1'b1;
            end
            G_CPU: begin
              if (!mem_we_q) cpu_dout_d = rd_byte;
              cpu_ack_d = 1'b1;
            end
            G_FDD: begin
              fdd_dout_d = rd_byte;
              fdd_ack_d  = 1'b1;
            end
            default: io_ack_d = 1'b1;
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= G_VID;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 8'h00;
      busy_q     <= 1'b0;
      vid_dout_q <= 16'h0000;
      cpu_dout_q <= 8'h00;
      fdd_dout_q <= 8'h00;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      fdd_ack_q  <= 1'b0;
      io_ack_q   <= 1'b0;
      fdd_age_q  <= '0;
      io_age_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      busy_q     <= busy_d;
      vid_dout_q <= vid_dout_d;
      cpu_dout_q <= cpu_dout_d;
      fdd_dout_q <= fdd_dout_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      fdd_ack_q  <= fdd_ack_d;
      io_ack_q   <= io_ack_d;
      fdd_age_q  <= fdd_age_d;
      io_age_q   <= io_age_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;

  assign vid_dout  = vid_dout_q;
  assign cpu_dout  = cpu_dout_q;
  assign fdd_dout  = fdd_dout_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign fdd_ack   = fdd_ack_q;
  assign io_ack    = io_ack_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, priority, aging, writes,
// reset abort and back-to-back CPU traffic against hand-computed values.
module tb_mem_arbiter;
  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [15:0]   vid_dout;
  logic          vid_ack;
  logic          cpu_req = 1'b0;
  logic          cpu_we  = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = 8'h00;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          fdd_req = 1'b0;
  logic [AW-1:0] fdd_addr = '0;
  logic [7:0]    fdd_dout;
  logic          fdd_ack;
  logic          io_req = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [7:0]    io_din = 8'h00;
  logic          io_ack;
  logic          busy;
  logic [1:0]    grant;
  logic [1:0]    state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_vid_dout = 16'h0000;
  logic [7:0]  exp_cpu_dout = 8'h00;
  logic [7:0]  exp_fdd_dout = 8'h00;

  mem_arbiter_if #(.AW(AW)) mem_if ();

  mem_arbiter #(.AW(AW), .AGE_W(4), .AGE_LIMIT(15)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_dout (vid_dout),
    .vid_ack  (vid_ack),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .fdd_req  (fdd_req),
    .fdd_addr (fdd_addr),
    .fdd_dout (fdd_dout),
    .fdd_ack  (fdd_ack),
    .io_req   (io_req),
    .io_addr  (io_addr),
    .io_din   (io_din),
    .io_ack   (io_ack),
    .mem      (mem_if),
    .busy     (busy),
    .grant    (grant),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: these only move stimulus and report timeouts through ok.
  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (mem_if.mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the first negedge with mem_req high; returns at the DONE-cycle negedge.
  task automatic serve(input logic [15:0] d, input int lat);
    repeat (lat - 1) @(negedge clk_sys);
    mem_if.mem_dout = d;
    mem_if.mem_ack  = 1'b1;
    @(negedge clk_sys);
    mem_if.mem_ack  = 1'b0;
  endtask

  // Serves CPU/FDD traffic until FDD is granted; counts CPU grants seen first.
  task automatic run_until_fdd(output int cpu_cnt, output bit fdd_seen, output bit timeout);
    bit ok;
    logic [1:0] g;
    cpu_cnt  = 0;
    fdd_seen = 1'b0;
    timeout  = 1'b0;
    for (int t = 0; t < 24 && !fdd_seen; t++) begin
      wait_mem_req(ok);
      if (!ok) begin
        timeout = 1'b1;
        break;
      end
      g = grant;
      if (g == 2'd2) begin
        serve(16'hC3D4, 1);
        fdd_req  = 1'b0;
        fdd_seen = 1'b1;
      end else begin
        serve(16'h9966, 1);
        if (g == 2'd1) cpu_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    vectors++; if (mem_if.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset mem_req: got %b want 0", mem_if.mem_req); end
    vectors++; if (mem_if.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset mem_we: got %b want 0", mem_if.mem_we); end
    vectors++; if (mem_if.mem_addr !== 25'h0) begin miscompares++; $display("FAIL reset mem_addr: got %h want 0", mem_if.mem_addr); end
    vectors++; if (mem_if.mem_din !== 8'h00) begin miscompares++; $display("FAIL reset mem_din: got %h want 0", mem_if.mem_din); end
    vectors++; if ({busy, vid_ack, cpu_ack, fdd_ack, io_ack} !== 5'b0) begin miscompares++; $display("FAIL reset busy/acks: got %b want 00000", {busy, vid_ack, cpu_ack, fdd_ack, io_ack}); end
    vectors++; if ({vid_dout, cpu_dout, fdd_dout} !== 32'h0) begin miscompares++; $display("FAIL reset douts: got %h want 0", {vid_dout, cpu_dout, fdd_dout}); end
    vectors++; if ({grant, state_dbg} !== 4'h0) begin miscompares++; $display("FAIL reset grant/state: got %h want 0", {grant, state_dbg}); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_cpu_read();
    bit ok;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h00101;
    wait_mem_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL cpu_read timeout: got no mem_req want mem_req=1"); end
    vectors++; if (grant !== 2'd1) begin miscompares++; $display("FAIL cpu_read grant: got %0d want 1", grant); end
    vectors++; if (mem_if.mem_addr !== 25'h00101) begin miscompares++; $display("FAIL cpu_read mem_addr: got %h want 00101", mem_if.mem_addr); end
    vectors++; if (mem_if.mem_we !== 1'b0) begin miscompares++; $display("FAIL cpu_read mem_we: got %b want 0", mem_if.mem_we); end
    vectors++; if ({busy, state_dbg} !== 3'b101) begin miscompares++; $display("FAIL cpu_read busy/state: got %b want 101", {busy, state_dbg}); end
    cpu_addr = 25'h001FF;
    repeat (3) @(negedge clk_sys);
    vectors++; if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 25'h00101}) begin miscompares++; $display("FAIL cpu_read hold: got req=%b addr=%h want req=1 addr=00101", mem_if.mem_req, mem_if.mem_addr); end
    mem_if.mem_dout = 16'hA55A;
    mem_if.mem_ack  = 1'b1;
    @(negedge clk_sys);
    mem_if.mem_ack = 1'b0;
    vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("FAIL cpu_read ack: got %b want 1", cpu_ack); end
    vectors++; if (cpu_dout !== 8'hA5) begin miscompares++; $display("FAIL cpu_read dout: got %h want a5", cpu_dout); end
    vectors++; if ({mem_if.mem_req, busy, state_dbg} !== 4'b0010) begin miscompares++; $display("FAIL cpu_read done: got %b want 0010", {mem_if.mem_req, busy, state_dbg}); end
    exp_cpu_dout = 8'hA5;
    cpu_req = 1'b0;
    @(negedge clk_sys);
    vectors++; if ({cpu_ack, state_dbg} !== 3'b000) begin miscompares++; $display("FAIL cpu_read after: got ack/state %b want 000", {cpu_ack, state_dbg}); end
    @(negedge clk_sys);
  endtask

  task automatic test_priority();
    bit ok;
    vid_req  = 1'b1;
    vid_addr = 25'h0ABCD;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h00200;
    wait_mem_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL prio vid timeout: got no mem_req want mem_req=1"); end
    vectors++; if ({grant, mem_if.mem_addr} !== {2'd0, 25'h0ABCD}) begin miscompares++; $display("FAIL prio vid grant/addr: got %0d/%h want 0/0abcd", grant, mem_if.mem_addr); end
    serve(16'h1234, 2);
    vectors++; if ({vid_ack, cpu_ack} !== 2'b10) begin miscompares++; $display("FAIL prio vid acks: got %b want 10", {vid_ack, cpu_ack}); end
    vectors++; if (vid_dout !== 16'h1234) begin miscompares++; $display("FAIL prio vid dout: got %h want 1234", vid_dout); end
    exp_vid_dout = 16'h1234;
    vid_req = 1'b0;
    @(negedge clk_sys);
    vectors++; if ({vid_ack, state_dbg} !== 3'b000) begin miscompares++; $display("FAIL prio idle: got %b want 000", {vid_ack, state_dbg}); end
    wait_mem_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL prio cpu timeout: got no mem_req want mem_req=1"); end
    vectors++; if ({grant, mem_if.mem_addr} !== {2'd1, 25'h00200}) begin miscompares++; $display("FAIL prio cpu grant/addr: got %0d/%h want 1/00200", grant, mem_if.mem_addr); end
    serve(16'hBEEF, 1);
    vectors++; if ({vid_ack, cpu_ack} !== 2'b01) begin miscompares++; $display("FAIL prio cpu acks: got %b want 01", {vid_ack, cpu_ack}); end
    vectors++; if ({cpu_dout, vid_dout} !== {8'hEF, exp_vid_dout}) begin miscompares++; $display("FAIL prio cpu dout: got %h/%h want ef/%h", cpu_dout, vid_dout, exp_vid_dout); end
    exp_cpu_dout = 8'hEF;
    cpu_req = 1'b0;
    @(negedge clk_sys);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL prio cpu ack width: got %b want 0", cpu_ack); end
    @(negedge clk_sys);
  endtask

  task automatic test_starvation();
    bit ok, seen, tmo;
    int cnt;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h00300;
    fdd_req  = 1'b1;
    fdd_addr = 25'h00033;
    run_until_fdd(cnt, seen, tmo);
    vectors++; if (tmo || !seen) begin miscompares++; $display("FAIL starve1 fdd grant: got seen=%b timeout=%b want seen=1 timeout=0", seen, tmo); end
    vectors++; if (cnt !== 15) begin miscompares++; $display("FAIL starve1 cpu count: got %0d want 15", cnt); end
    vectors++; if ({fdd_ack, fdd_dout} !== {1'b1, 8'hC3}) begin miscompares++; $display("FAIL starve1 fdd ack/dout: got %b/%h want 1/c3", fdd_ack, fdd_dout); end
    vectors++; if (cpu_dout !== 8'h66) begin miscompares++; $display("FAIL starve1 cpu dout: got %h want 66", cpu_dout); end
    exp_fdd_dout = 8'hC3;
    exp_cpu_dout = 8'h66;
    wait_mem_req(ok);
    vectors++; if (!ok || grant !== 2'd1) begin miscompares++; $display("FAIL starve resume: got ok=%b grant=%0d want ok=1 grant=1", ok, grant); end
    serve(16'h9966, 1);
    fdd_req = 1'b1;
    run_until_fdd(cnt, seen, tmo);
    vectors++; if (tmo || !seen) begin miscompares++; $display("FAIL starve2 fdd grant: got seen=%b timeout=%b want seen=1 timeout=0", seen, tmo); end
    vectors++; if (cnt !== 15) begin miscompares++; $display("FAIL starve2 cpu count (age reset): got %0d want 15", cnt); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    vectors++; if ({mem_if.mem_req, state_dbg} !== 3'b000) begin miscompares++; $display("FAIL starve idle: got %b want 000", {mem_if.mem_req, state_dbg}); end
  endtask

  task automatic test_writes();
    bit ok;
    io_req  = 1'b1;
    io_addr = 25'h0A0000;
    io_din  = 8'h3C;
    wait_mem_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL io_write timeout: got no mem_req want mem_req=1"); end
    vectors++; if ({grant, mem_if.mem_we, mem_if.mem_din} !== {2'd3, 1'b1, 8'h3C}) begin miscompares++; $display("FAIL io_write bus: got grant=%0d we=%b din=%h want 3/1/3c", grant, mem_if.mem_we, mem_if.mem_din); end
    vectors++; if (mem_if.mem_addr !== 25'h0A0000) begin miscompares++; $display("FAIL io_write addr: got %h want 0a0000", mem_if.mem_addr); end
    serve(16'hFFFF, 2);
    vectors++; if ({io_ack, cpu_ack, fdd_ack, vid_ack} !== 4'b1000) begin miscompares++; $display("FAIL io_write acks: got %b want 1000", {io_ack, cpu_ack, fdd_ack, vid_ack}); end
    vectors++; if ({vid_dout, cpu_dout, fdd_dout} !== {exp_vid_dout, exp_cpu_dout, exp_fdd_dout}) begin miscompares++; $display("FAIL io_write douts: got %h want %h", {vid_dout, cpu_dout, fdd_dout}, {exp_vid_dout, exp_cpu_dout, exp_fdd_dout}); end
    io_req = 1'b0;
    @(negedge clk_sys);
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 25'h00401;
    cpu_din  = 8'h77;
    wait_mem_req(ok);
    vectors++; if (!ok || {grant, mem_if.mem_we, mem_if.mem_din} !== {2'd1, 1'b1, 8'h77}) begin miscompares++; $display("FAIL cpu_write bus: got ok=%b grant=%0d we=%b din=%h want 1/1/1/77", ok, grant, mem_if.mem_we, mem_if.mem_din); end
    serve(16'hEEEE, 1);
    vectors++; if ({cpu_ack, cpu_dout} !== {1'b1, exp_cpu_dout}) begin miscompares++; $display("FAIL cpu_write ack/dout: got %b/%h want 1/%h", cpu_ack, cpu_dout, exp_cpu_dout); end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid();
    bit ok;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h00500;
    wait_mem_req(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_mid timeout: got no mem_req want mem_req=1"); end
    reset           = 1'b1;
    mem_if.mem_dout = 16'h4242;
    mem_if.mem_ack  = 1'b1;
    @(negedge clk_sys);
    vectors++; if ({mem_if.mem_req, busy, state_dbg} !== 4'b0000) begin miscompares++; $display("FAIL rst_mid abort: got req/busy/state %b want 0000", {mem_if.mem_req, busy, state_dbg}); end
    vectors++; if ({vid_ack, cpu_ack, fdd_ack, io_ack} !== 4'b0) begin miscompares++; $display("FAIL rst_mid acks: got %b want 0000", {vid_ack, cpu_ack, fdd_ack, io_ack}); end
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk_sys);
    vectors++; if ({vid_ack, cpu_ack, fdd_ack, io_ack, state_dbg} !== 6'b0) begin miscompares++; $display("FAIL rst_mid stray ack: got %b want 000000", {vid_ack, cpu_ack, fdd_ack, io_ack, state_dbg}); end
    mem_if.mem_ack = 1'b0;
    exp_cpu_dout = 8'h00;
    exp_fdd_dout = 8'h00;
    exp_vid_dout = 16'h0000;
    vectors++; if (cpu_dout !== exp_cpu_dout) begin miscompares++; $display("FAIL rst_mid cpu dout: got %h want 00", cpu_dout); end
    @(negedge clk_sys);
  endtask

  task automatic test_back_to_back();
    bit ok;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h00010;
    wait_mem_req(ok);
    vectors++; if (!ok || mem_if.mem_addr !== 25'h00010) begin miscompares++; $display("FAIL b2b first addr: got ok=%b addr=%h want 1/00010", ok, mem_if.mem_addr); end
    serve(16'h1122, 1);
    vectors++; if ({cpu_ack, cpu_dout} !== {1'b1, 8'h22}) begin miscompares++; $display("FAIL b2b first ack/dout: got %b/%h want 1/22", cpu_ack, cpu_dout); end
    cpu_addr = 25'h00011;
    @(negedge clk_sys);
    vectors++; if ({cpu_ack, mem_if.mem_req, state_dbg} !== 4'b0000) begin miscompares++; $display("FAIL b2b idle gap: got %b want 0000", {cpu_ack, mem_if.mem_req, state_dbg}); end
    @(negedge clk_sys);
    vectors++; if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b1, 25'h00011}) begin miscompares++; $display("FAIL b2b second start: got req=%b addr=%h want 1/00011", mem_if.mem_req, mem_if.mem_addr); end
    serve(16'h3344, 1);
    vectors++; if ({cpu_ack, cpu_dout} !== {1'b1, 8'h33}) begin miscompares++; $display("FAIL b2b second ack/dout: got %b/%h want 1/33", cpu_ack, cpu_dout); end
    cpu_req = 1'b0;
    @(negedge clk_sys);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL b2b ack width: got %b want 0", cpu_ack); end
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_dout = 16'h0000;
    test_reset();
    test_cpu_read();
    test_priority();
    test_starvation();
    test_writes();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
